// File: rtl/global_pkg.sv
// Shared types for the core: memory operation encoding, load/store funct3 codes,
// memory access unit FSM states and the access legality check.
package global_pkg;

   typedef enum logic [1:0] {
      MEM_NONE   = 2'd0,
      FETCH_DATA = 2'd1,
      LOAD_DATA  = 2'd2,
      STORE_DATA = 2'd3
   } memory_operation_t;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      RESP = 2'd2
   } mau_state_t;

   // True when the funct3 code exists for this operation and the address is naturally aligned.
   function automatic logic access_legal(memory_operation_t op, logic [2:0] f3, logic [1:0] addr_lo);
      logic ok;
      ok = 1'b0;
      case (op)
         FETCH_DATA: ok = (addr_lo == 2'b00);
         LOAD_DATA: begin
            case (f3)
               LB, LBU: ok = 1'b1;
               LH, LHU: ok = ~addr_lo[0];
               LW:      ok = (addr_lo == 2'b00);
               default: ok = 1'b0;
            endcase
         end
         STORE_DATA: begin
            case (f3)
               SB:      ok = 1'b1;
               SH:      ok = ~addr_lo[0];
               SW:      ok = (addr_lo == 2'b00);
               default: ok = 1'b0;
            endcase
         end
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_formatter.sv
// Extracts the addressed byte/halfword lane from a bus read word and
// sign- or zero-extends it according to the load funct3.
import global_pkg::*;

module load_formatter (
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [31:0] shifted;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      shifted   = rdata >> {addr_lo, 3'b000};
      byte_lane = shifted[7:0];
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      case (funct3)
         LB:      result = {{24{byte_lane[7]}}, byte_lane};
         LH:      result = {{16{half_lane[15]}}, half_lane};
         LBU:     result = {24'd0, byte_lane};
         LHU:     result = {16'd0, half_lane};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/memory_access_unit.sv
// Executes fetch/load/store requests from the control unit as single Wishbone-classic cycles.
// Optional bus watchdog enabled by defining MAU_BUS_TIMEOUT_EN.
import global_pkg::*;

module memory_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  memory_operation_t memory_operation,
   input  logic              cyc,
   input  logic [2:0]        funct3,
   input  logic [31:0]       pc,
   input  logic [31:0]       ls_addr,
   input  logic [31:0]       store_data,
   output logic              ack,
   output logic              data_valid,
   output logic              done,
   output logic              err,
   output logic [31:0]       fetched_data,
   output logic [31:0]       wb_adr_o,
   output logic [31:0]       wb_dat_o,
   input  logic [31:0]       wb_dat_i,
   output logic [3:0]        wb_sel_o,
   output logic              wb_we_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   input  logic              wb_ack_i,
   input  logic              wb_err_i
);

   mau_state_t        state_q, state_d;
   memory_operation_t op_q;
   logic [2:0]        f3_q;
   logic [31:0]       addr_q;
   logic [31:0]       sdata_q;
   logic              err_q, err_d;
   logic              ack_q, ack_d;
   logic              capture;
   logic              load_result;
   logic              timeout;
   logic [2:0]        req_f3;
   logic [31:0]       req_addr;
   logic [31:0]       formatted;
   logic              in_bus;

   // Fetches are always full words, so they are recorded as LW and read back raw.
   assign req_f3   = (memory_operation == FETCH_DATA) ? LW : funct3;
   assign req_addr = (memory_operation == FETCH_DATA) ? pc : ls_addr;

   load_formatter u_load_formatter (
      .rdata   (wb_dat_i),
      .addr_lo (addr_q[1:0]),
      .funct3  (f3_q),
      .result  (formatted)
   );

`ifdef MAU_BUS_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] tmo_cnt_q;

   always_ff @(posedge clk) begin
      if (rst || state_q != BUS) begin
         tmo_cnt_q <= '0;
      end else if (!wb_ack_i && !wb_err_i) begin
         tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
   end

   // Fires in the last permitted silent BUS cycle so the cycle ends after exactly TIMEOUT_CYCLES.
   assign timeout = (state_q == BUS) && !wb_ack_i && !wb_err_i &&
                    (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_timeout_cycles;
   assign unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ack_d       = 1'b0;
      err_d       = err_q;
      capture     = 1'b0;
      load_result = 1'b0;
      case (state_q)
         IDLE: begin
            if (cyc && memory_operation != MEM_NONE) begin
               capture = 1'b1;
               ack_d   = 1'b1;
               if (access_legal(memory_operation, req_f3, req_addr[1:0])) begin
                  err_d   = 1'b0;
                  state_d = BUS;
               end else begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end
            end
         end
         BUS: begin
            if (wb_err_i || timeout) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else if (wb_ack_i) begin
               err_d       = 1'b0;
               load_result = (op_q != STORE_DATA);
               state_d     = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= MEM_NONE;
         f3_q         <= 3'd0;
         addr_q       <= 32'd0;
         sdata_q      <= 32'd0;
         err_q        <= 1'b0;
         ack_q        <= 1'b0;
         fetched_data <= 32'd0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         if (capture) begin
            op_q    <= memory_operation;
            f3_q    <= req_f3;
            addr_q  <= req_addr;
            sdata_q <= store_data;
         end
         if (load_result) begin
            fetched_data <= formatted;
         end
      end
   end

   // Bus outputs are decoded from the state register, so a reset drops the cycle at that edge.
   always_comb begin
      in_bus   = (state_q == BUS);
      wb_cyc_o = in_bus;
      wb_stb_o = in_bus;
      wb_adr_o = in_bus ? {addr_q[31:2], 2'b00} : 32'd0;
      wb_we_o  = in_bus && (op_q == STORE_DATA);
      wb_sel_o = 4'b0000;
      wb_dat_o = 32'd0;
      if (in_bus) begin
         wb_sel_o = 4'b1111;
         if (op_q == STORE_DATA) begin
            case (f3_q)
               SB: begin
                  wb_sel_o = 4'b0001 << addr_q[1:0];
                  wb_dat_o = {4{sdata_q[7:0]}};
               end
               SH: begin
                  wb_sel_o = addr_q[1] ? 4'b1100 : 4'b0011;
                  wb_dat_o = {2{sdata_q[15:0]}};
               end
               default: begin
                  wb_sel_o = 4'b1111;
                  wb_dat_o = sdata_q;
               end
            endcase
         end
      end
   end

   assign ack        = ack_q;
   assign done       = (state_q == RESP);
   assign err        = done && err_q;
   assign data_valid = done && !err_q && (op_q != STORE_DATA);

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed scoreboard bench for memory_access_unit: stimulus queues expected bus cycles and
// responses, a slave model and a response monitor pop and compare them independently.
import global_pkg::*;

module tb_memory_access_unit;

`ifdef MAU_BUS_TIMEOUT_EN
   localparam int unsigned TMO = 4;
`else
   localparam int unsigned TMO = 255;
`endif

   localparam int M_ACK    = 0;
   localparam int M_ERR    = 1;
   localparam int M_BOTH   = 2;
   localparam int M_SILENT = 3;

   typedef struct {
      logic        err;
      logic        dv;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
   } bus_t;

   logic              clk;
   logic              rst;
   memory_operation_t memory_operation;
   logic              cyc;
   logic [2:0]        funct3;
   logic [31:0]       pc;
   logic [31:0]       ls_addr;
   logic [31:0]       store_data;
   logic              ack;
   logic              data_valid;
   logic              done;
   logic              err;
   logic [31:0]       fetched_data;
   logic [31:0]       wb_adr_o;
   logic [31:0]       wb_dat_o;
   logic [31:0]       wb_dat_i;
   logic [3:0]        wb_sel_o;
   logic              wb_we_o;
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_ack_i;
   logic              wb_err_i;

   resp_t exp_q[$];
   bus_t  bus_q[$];
   int    vectors;
   int    miscompares;
   int    cfg_waits;
   int    cfg_mode;
   logic [31:0] cfg_rdata;
   int    wait_cnt;
   logic  bus_active;

   memory_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk              (clk),
      .rst              (rst),
      .memory_operation (memory_operation),
      .cyc              (cyc),
      .funct3           (funct3),
      .pc               (pc),
      .ls_addr          (ls_addr),
      .store_data       (store_data),
      .ack              (ack),
      .data_valid       (data_valid),
      .done             (done),
      .err              (err),
      .fetched_data     (fetched_data),
      .wb_adr_o         (wb_adr_o),
      .wb_dat_o         (wb_dat_o),
      .wb_dat_i         (wb_dat_i),
      .wb_sel_o         (wb_sel_o),
      .wb_we_o          (wb_we_o),
      .wb_cyc_o         (wb_cyc_o),
      .wb_stb_o         (wb_stb_o),
      .wb_ack_i         (wb_ack_i),
      .wb_err_i         (wb_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Slave model: checks each new bus cycle against the queued expectation, then answers it.
   always @(posedge clk) begin
      #1;
      if (wb_cyc_o && wb_stb_o) begin
         if (!bus_active) begin
            bus_active = 1'b1;
            wait_cnt   = 0;
            if (bus_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_bus_cycle: got wb_cyc_o=1 at adr 0x%08h, expected no bus cycle", wb_adr_o);
            end else begin
               bus_t b;
               b = bus_q.pop_front();
               check_output("wb_adr_o", wb_adr_o, b.adr);
               check_output("wb_sel_o", {28'd0, wb_sel_o}, {28'd0, b.sel});
               check_output("wb_we_o", {31'd0, wb_we_o}, {31'd0, b.we});
               if (b.we) check_output("wb_dat_o", wb_dat_o, b.dat);
            end
         end
         if (cfg_mode != M_SILENT && wait_cnt == cfg_waits) begin
            wb_ack_i = (cfg_mode == M_ACK) || (cfg_mode == M_BOTH);
            wb_err_i = (cfg_mode == M_ERR) || (cfg_mode == M_BOTH);
            wb_dat_i = cfg_rdata;
         end else begin
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_dat_i = 32'd0;
         end
         wait_cnt++;
      end else begin
         bus_active = 1'b0;
         wb_ack_i   = 1'b0;
         wb_err_i   = 1'b0;
         wb_dat_i   = 32'd0;
      end
   end

   // Response monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_done: got done=1 err=%0b, expected no response", err);
         end else begin
            resp_t r;
            r = exp_q.pop_front();
            check_output("resp_err", {31'd0, err}, {31'd0, r.err});
            check_output("resp_data_valid", {31'd0, data_valid}, {31'd0, r.dv});
            check_output("resp_fetched_data", fetched_data, r.data);
         end
      end else if (!rst && (data_valid || err)) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL pulse_without_done: got data_valid=%0b err=%0b, expected both 0", data_valid, err);
      end
   end

   // Issues one request, checks the ack pulse and the request-to-done latency in cycles.
   task automatic apply_stimulus(input memory_operation_t op, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] sdata, input int waits, input int mode, input logic [31:0] rdata,
                                 input logic has_bus, input logic [31:0] b_adr, input logic [3:0] b_sel,
                                 input logic [31:0] b_dat, input logic exp_err, input logic exp_dv,
                                 input logic [31:0] exp_data, input int exp_lat);
      resp_t r;
      bus_t  b;
      int    lat;
      r.err  = exp_err;
      r.dv   = exp_dv;
      r.data = exp_data;
      exp_q.push_back(r);
      if (has_bus) begin
         b.adr = b_adr;
         b.sel = b_sel;
         b.dat = b_dat;
         b.we  = (op == STORE_DATA);
         bus_q.push_back(b);
      end
      cfg_waits        = waits;
      cfg_mode         = mode;
      cfg_rdata        = rdata;
      memory_operation = op;
      funct3           = f3;
      pc               = (op == FETCH_DATA) ? addr : 32'hFFFF_FFFC;
      ls_addr          = (op == FETCH_DATA) ? 32'hFFFF_FFFC : addr;
      store_data       = sdata;
      cyc              = 1'b1;
      @(posedge clk);
      #1;
      check_output("ack_pulse", {31'd0, ack}, 32'd1);
      cyc              = 1'b0;
      memory_operation = MEM_NONE;
      lat = 0;
      for (int i = 1; i <= 50; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) $display("[TB] FAIL done_timeout: got no done within 50 cycles, expected done after %0d", exp_lat);
      check_output("done_latency", lat, exp_lat);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst              = 1'b1;
      cyc              = 1'b0;
      memory_operation = MEM_NONE;
      funct3           = 3'd0;
      pc               = 32'd0;
      ls_addr          = 32'd0;
      store_data       = 32'd0;
      cfg_waits        = 0;
      cfg_mode         = M_ACK;
      cfg_rdata        = 32'd0;
      wb_dat_i         = 32'd0;
      wb_ack_i         = 1'b0;
      wb_err_i         = 1'b0;
      bus_active       = 1'b0;
      wait_cnt         = 0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_ack", {31'd0, ack}, 32'd0);
      check_output("reset_done", {31'd0, done}, 32'd0);
      check_output("reset_err", {31'd0, err}, 32'd0);
      check_output("reset_data_valid", {31'd0, data_valid}, 32'd0);
      check_output("reset_fetched_data", fetched_data, 32'd0);
      check_output("reset_wb_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
      check_output("reset_wb_we_sel", {27'd0, wb_we_o, wb_sel_o}, 32'd0);
      check_output("reset_wb_adr", wb_adr_o, 32'd0);
      check_output("reset_wb_dat", wb_dat_o, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      //             op          f3      addr          sdata         w  mode      rdata         bus   adr           sel      dat           err   dv    data          lat
      apply_stimulus(FETCH_DATA, 3'b000, 32'h0000_0010, 32'd0,        0, M_ACK,    32'h0050_0093, 1'b1, 32'h0000_0010, 4'b1111, 32'd0,        1'b0, 1'b1, 32'h0050_0093, 2);
      apply_stimulus(LOAD_DATA,  LB,     32'h0000_0103, 32'd0,        0, M_ACK,    32'h80FF_1234, 1'b1, 32'h0000_0100, 4'b1111, 32'd0,        1'b0, 1'b1, 32'hFFFF_FF80, 2);
      apply_stimulus(LOAD_DATA,  LBU,    32'h0000_0103, 32'd0,        0, M_ACK,    32'h80FF_1234, 1'b1, 32'h0000_0100, 4'b1111, 32'd0,        1'b0, 1'b1, 32'h0000_0080, 2);
      apply_stimulus(LOAD_DATA,  LH,     32'h0000_0102, 32'd0,        0, M_ACK,    32'h80FF_1234, 1'b1, 32'h0000_0100, 4'b1111, 32'd0,        1'b0, 1'b1, 32'hFFFF_80FF, 2);
      apply_stimulus(LOAD_DATA,  LHU,    32'h0000_0100, 32'd0,        0, M_ACK,    32'h80FF_1234, 1'b1, 32'h0000_0100, 4'b1111, 32'd0,        1'b0, 1'b1, 32'h0000_1234, 2);
      apply_stimulus(STORE_DATA, SH,     32'h0000_0202, 32'h0000_BEEF, 0, M_ACK,   32'd0,        1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0000_1234, 2);
      apply_stimulus(STORE_DATA, SB,     32'h0000_0301, 32'h1234_56A5, 0, M_ACK,   32'd0,        1'b1, 32'h0000_0300, 4'b0010, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0000_1234, 2);
      apply_stimulus(STORE_DATA, SW,     32'h0000_0400, 32'hDEAD_BEEF, 1, M_ACK,   32'd0,        1'b1, 32'h0000_0400, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_1234, 3);
      apply_stimulus(LOAD_DATA,  LW,     32'h0000_0101, 32'd0,        0, M_ACK,    32'd0,        1'b0, 32'd0,        4'b0000, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 1);
      apply_stimulus(STORE_DATA, SH,     32'h0000_0203, 32'h0000_1111, 0, M_ACK,   32'd0,        1'b0, 32'd0,        4'b0000, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 1);
      apply_stimulus(LOAD_DATA,  3'b011, 32'h0000_0100, 32'd0,        0, M_ACK,    32'd0,        1'b0, 32'd0,        4'b0000, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 1);
      apply_stimulus(STORE_DATA, 3'b100, 32'h0000_0100, 32'h0000_2222, 0, M_ACK,   32'd0,        1'b0, 32'd0,        4'b0000, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 1);
      apply_stimulus(LOAD_DATA,  LW,     32'h0000_0500, 32'd0,        3, M_BOTH,   32'h1234_5678, 1'b1, 32'h0000_0500, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 5);
      apply_stimulus(FETCH_DATA, 3'b111, 32'h0000_0600, 32'd0,        0, M_ERR,    32'hCAFE_F00D, 1'b1, 32'h0000_0600, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h0000_1234, 2);

      // Reset while the bus cycle is pending: the cycle must drop at that edge with no response.
      begin
         bus_t b;
         b.adr = 32'h0000_0700;
         b.sel = 4'b1111;
         b.dat = 32'd0;
         b.we  = 1'b0;
         bus_q.push_back(b);
      end
      cfg_mode         = M_SILENT;
      memory_operation = FETCH_DATA;
      pc               = 32'h0000_0700;
      cyc              = 1'b1;
      @(posedge clk);
      #1;
      check_output("rst_case_ack", {31'd0, ack}, 32'd1);
      cyc              = 1'b0;
      memory_operation = MEM_NONE;
      @(posedge clk);
      #1;
      check_output("rst_case_in_bus", {31'd0, wb_cyc_o}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_output("rst_case_cyc_dropped", {31'd0, wb_cyc_o}, 32'd0);
      check_output("rst_case_no_done", {31'd0, done}, 32'd0);
      check_output("rst_case_fetched_cleared", fetched_data, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_output("rst_case_still_no_done", {31'd0, done}, 32'd0);

      apply_stimulus(FETCH_DATA, 3'b000, 32'h0000_0020, 32'd0,        0, M_ACK,    32'h1122_3344, 1'b1, 32'h0000_0020, 4'b1111, 32'd0,        1'b0, 1'b1, 32'h1122_3344, 2);
`ifdef MAU_BUS_TIMEOUT_EN
      apply_stimulus(LOAD_DATA,  LW,     32'h0000_0800, 32'd0,        0, M_SILENT, 32'd0,        1'b1, 32'h0000_0800, 4'b1111, 32'd0,        1'b1, 1'b0, 32'h1122_3344, 5);
`endif

      repeat (3) @(posedge clk);
      #1;
      check_output("scoreboard_drained", exp_q.size() + bus_q.size(), 32'd0);
      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got simulation still running, expected completion");
      $fatal(1, "[TB] bench did not complete");
   end

endmodule
